// File: rtl/usb_device_fsm.sv
// Device-side transaction controller: waits for a token, then runs the OUT
// (receive data, send handshake) or IN (send data, receive handshake) exchange.
module usb_device_fsm #(
    parameter int unsigned MAX_RETRY = 8
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       token_valid,
    input  logic       token_out,
    output logic       r_token,
    output logic       r_data_start,
    input  logic       r_data_finish,
    input  logic       r_data_fail,
    output logic       start_send_data,
    input  logic       done_send_data,
    output logic       start_send_hand,
    output logic       send_ack,
    input  logic       done_send_hand,
    output logic       r_hand,
    input  logic       r_hand_ack,
    input  logic       r_hand_nak,
    input  logic       r_hand_fail,
    output logic       transfer_done,
    output logic       transfer_ok,
    output logic [3:0] fail_count,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        R_DATA,
        S_HAND,
        S_DATA,
        R_HAND
    } state_t;

    localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

    state_t     state, state_nxt;
    logic       r_data_start_nxt, start_send_data_nxt, start_send_hand_nxt, r_hand_nxt;
    logic       transfer_done_nxt, transfer_ok_nxt, send_ack_nxt;
    logic [3:0] fail_nxt, fail_inc;

    assign fail_inc = (fail_count == 4'hF) ? 4'hF : fail_count + 4'd1;
    assign r_token  = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt           = state;
        r_data_start_nxt    = 1'b0;
        start_send_data_nxt = 1'b0;
        start_send_hand_nxt = 1'b0;
        r_hand_nxt          = 1'b0;
        transfer_done_nxt   = 1'b0;
        transfer_ok_nxt     = transfer_ok;
        send_ack_nxt        = send_ack;
        fail_nxt            = fail_count;
        case (state)
            IDLE: begin
                // transfer_done high means we only just returned here; drop the token
                if (token_valid && !transfer_done) begin
                    fail_nxt        = '0;
                    transfer_ok_nxt = 1'b0;
                    if (token_out) begin
                        state_nxt        = R_DATA;
                        r_data_start_nxt = 1'b1;
                    end else begin
                        state_nxt           = S_DATA;
                        start_send_data_nxt = 1'b1;
                    end
                end
            end
            R_DATA: begin
                if (r_data_fail) begin
                    fail_nxt            = fail_inc;
                    send_ack_nxt        = 1'b0;
                    state_nxt           = S_HAND;
                    start_send_hand_nxt = 1'b1;
                end else if (r_data_finish) begin
                    send_ack_nxt        = 1'b1;
                    state_nxt           = S_HAND;
                    start_send_hand_nxt = 1'b1;
                end
            end
            S_HAND: begin
                if (done_send_hand) begin
                    if (send_ack) begin
                        state_nxt         = IDLE;
                        transfer_done_nxt = 1'b1;
                        transfer_ok_nxt   = 1'b1;
                    end else if (fail_count <= RETRY_LIM) begin
                        state_nxt        = R_DATA;
                        r_data_start_nxt = 1'b1;
                    end else begin
                        state_nxt         = IDLE;
                        transfer_done_nxt = 1'b1;
                        transfer_ok_nxt   = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (done_send_data) begin
                    state_nxt  = R_HAND;
                    r_hand_nxt = 1'b1;
                end
            end
            R_HAND: begin
                if (r_hand_nak || r_hand_fail) begin
                    fail_nxt = fail_inc;
                    if (fail_inc <= RETRY_LIM) begin
                        state_nxt           = S_DATA;
                        start_send_data_nxt = 1'b1;
                    end else begin
                        state_nxt         = IDLE;
                        transfer_done_nxt = 1'b1;
                        transfer_ok_nxt   = 1'b0;
                    end
                end else if (r_hand_ack) begin
                    state_nxt         = IDLE;
                    transfer_done_nxt = 1'b1;
                    transfer_ok_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state           <= IDLE;
            r_data_start    <= 1'b0;
            start_send_data <= 1'b0;
            start_send_hand <= 1'b0;
            r_hand          <= 1'b0;
            transfer_done   <= 1'b0;
            transfer_ok     <= 1'b0;
            send_ack        <= 1'b0;
            fail_count      <= '0;
        end else begin
            state           <= state_nxt;
            r_data_start    <= r_data_start_nxt;
            start_send_data <= start_send_data_nxt;
            start_send_hand <= start_send_hand_nxt;
            r_hand          <= r_hand_nxt;
            transfer_done   <= transfer_done_nxt;
            transfer_ok     <= transfer_ok_nxt;
            send_ack        <= send_ack_nxt;
            fail_count      <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_usb_device_fsm.sv
// Self-checking bench for usb_device_fsm: cycle-exact vector table, directed
// corner sequences and randomized transactions against a transaction-level model.
module tb_usb_device_fsm;

    localparam int MAX_RETRY = 8;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       token_valid = 1'b0, token_out = 1'b0;
    logic       r_data_finish = 1'b0, r_data_fail = 1'b0;
    logic       done_send_data = 1'b0, done_send_hand = 1'b0;
    logic       r_hand_ack = 1'b0, r_hand_nak = 1'b0, r_hand_fail = 1'b0;
    logic       r_token, r_data_start, start_send_data, start_send_hand, send_ack, r_hand;
    logic       transfer_done, transfer_ok, busy;
    logic [3:0] fail_count;

    int vectors = 0;
    int miscompares = 0;

    // Pulse counters sampled mid-cycle, independent of the checking thread
    int n_rds = 0, n_ssd = 0, n_nak = 0, n_rh = 0;

    usb_device_fsm #(.MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_l(rst_l),
        .token_valid(token_valid), .token_out(token_out), .r_token(r_token),
        .r_data_start(r_data_start), .r_data_finish(r_data_finish), .r_data_fail(r_data_fail),
        .start_send_data(start_send_data), .done_send_data(done_send_data),
        .start_send_hand(start_send_hand), .send_ack(send_ack), .done_send_hand(done_send_hand),
        .r_hand(r_hand), .r_hand_ack(r_hand_ack), .r_hand_nak(r_hand_nak), .r_hand_fail(r_hand_fail),
        .transfer_done(transfer_done), .transfer_ok(transfer_ok),
        .fail_count(fail_count), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (r_data_start) n_rds++;
        if (start_send_data) n_ssd++;
        if (start_send_hand && !send_ack) n_nak++;
        if (r_hand) n_rh++;
    end

    typedef struct {
        logic [8:0] in;   // tv, to, finish, rfail, dsd, dsh, ack, nak, hfail
        logic [8:0] exp;  // r_token, busy, rds, ssd, ssh, send_ack, r_hand, done, ok
        logic [3:0] fc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [8:0] in, input logic [8:0] exp, input logic [3:0] fc);
        vec_t v;
        v.in = in; v.exp = exp; v.fc = fc;
        tbl.push_back(v);
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endfunction

    function automatic logic [8:0] outs();
        return {r_token, busy, r_data_start, start_send_data, start_send_hand,
                send_ack, r_hand, transfer_done, transfer_ok};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {token_valid, token_out, r_data_finish, r_data_fail, done_send_data,
         done_send_hand, r_hand_ack, r_hand_nak, r_hand_fail} = '0;
    endtask

    // Waiting cycles with noise on inputs the current path must ignore
    task automatic idle_cycles(input int n, input bit is_out);
        for (int i = 0; i < n; i++) begin
            token_valid = 1'($urandom_range(0, 1));
            token_out   = 1'($urandom_range(0, 1));
            if (is_out) begin
                done_send_data = 1'($urandom_range(0, 1));
                r_hand_nak     = 1'($urandom_range(0, 1));
            end else begin
                r_data_fail    = 1'($urandom_range(0, 1));
                done_send_hand = 1'($urandom_range(0, 1));
            end
            tick();
            clear_inputs();
            check("idle_busy", busy, 1);
            check("idle_pulses", {r_data_start, start_send_data, start_send_hand, r_hand, transfer_done}, 0);
        end
    endtask

    // nfail attempts fail before success; nfail > MAX_RETRY means it never succeeds
    task automatic run_txn(input bit is_out, input int nfail, input bit both_first, input int max_delay);
        int  exp_fc, exp_att, rq0, nak0, rh0;
        bit  exp_ok, fail_now;
        exp_ok  = (nfail <= MAX_RETRY);
        exp_fc  = exp_ok ? nfail : MAX_RETRY + 1;
        exp_att = exp_ok ? nfail + 1 : MAX_RETRY + 1;
        tick();
        check("txn_start_idle", r_token, 1);
        rq0 = is_out ? n_rds : n_ssd; nak0 = n_nak; rh0 = n_rh;
        token_valid = 1'b1; token_out = is_out;
        tick();
        clear_inputs();
        for (int a = 0; a < exp_att; a++) begin
            fail_now = (a < nfail);
            if (is_out) check("req_r_data_start", r_data_start, 1);
            else        check("req_start_send_data", start_send_data, 1);
            idle_cycles($urandom_range(0, max_delay), is_out);
            if (is_out) begin
                r_data_fail   = fail_now;
                r_data_finish = !fail_now || (both_first && a == 0);
                tick();
                clear_inputs();
                check("start_send_hand", start_send_hand, 1);
                check("send_ack", send_ack, !fail_now);
                idle_cycles($urandom_range(0, max_delay), is_out);
                done_send_hand = 1'b1;
                tick();
                clear_inputs();
            end else begin
                done_send_data = 1'b1;
                tick();
                clear_inputs();
                check("r_hand", r_hand, 1);
                idle_cycles($urandom_range(0, max_delay), is_out);
                if (fail_now) begin
                    r_hand_ack = both_first && a == 0;
                    if ($urandom_range(0, 1) == 1) r_hand_nak = 1'b1;
                    else r_hand_fail = 1'b1;
                end else begin
                    r_hand_ack = 1'b1;
                end
                tick();
                clear_inputs();
            end
        end
        check("txn_done", transfer_done, 1);
        check("txn_ok", transfer_ok, exp_ok);
        check("txn_fail_count", fail_count, exp_fc);
        check("txn_r_token", r_token, 1);
        check("txn_req_pulses", (is_out ? n_rds : n_ssd) - rq0, exp_att);
        if (is_out) check("txn_nak_count", n_nak - nak0, exp_fc);
        else        check("txn_r_hand_pulses", n_rh - rh0, exp_att);
    endtask

    initial begin
        // Cycle-exact sequence from reset: OUT clean, dropped token, IN with retries, OUT with 2 failures
        add(9'b110000000, 9'b011000000, 4'd0);
        add(9'b000000000, 9'b010000000, 4'd0);
        add(9'b001000100, 9'b010011000, 4'd0);
        add(9'b100000000, 9'b010001000, 4'd0);
        add(9'b000001000, 9'b100001011, 4'd0);
        add(9'b100000000, 9'b100001001, 4'd0);
        add(9'b100000000, 9'b010101000, 4'd0);
        add(9'b000010000, 9'b010001100, 4'd0);
        add(9'b000000010, 9'b010101000, 4'd1);
        add(9'b000010000, 9'b010001100, 4'd1);
        add(9'b000000101, 9'b010101000, 4'd2);
        add(9'b000010000, 9'b010001100, 4'd2);
        add(9'b000000100, 9'b100001011, 4'd2);
        add(9'b000000000, 9'b100001001, 4'd2);
        add(9'b110000000, 9'b011001000, 4'd0);
        add(9'b001100000, 9'b010010000, 4'd1);
        add(9'b000001000, 9'b011000000, 4'd1);
        add(9'b000100000, 9'b010010000, 4'd2);
        add(9'b000001000, 9'b011000000, 4'd2);
        add(9'b001000000, 9'b010011000, 4'd2);
        add(9'b000001000, 9'b100001011, 4'd2);

        repeat (3) tick();
        check("reset_outputs", outs(), 9'b100000000);
        check("reset_fail_count", fail_count, 0);
        @(negedge clk);
        rst_l = 1'b1;
        #4;
        foreach (tbl[i]) begin
            {token_valid, token_out, r_data_finish, r_data_fail, done_send_data,
             done_send_hand, r_hand_ack, r_hand_nak, r_hand_fail} = tbl[i].in;
            tick();
            clear_inputs();
            check($sformatf("vec%0d_outputs", i), outs(), tbl[i].exp);
            check($sformatf("vec%0d_fail_count", i), fail_count, tbl[i].fc);
        end

        // Directed multi-cycle corners
        run_txn(1'b1, 0, 1'b0, 0);
        run_txn(1'b1, 2, 1'b0, 1);
        run_txn(1'b1, 9, 1'b0, 0);
        run_txn(1'b0, 1, 1'b0, 0);
        run_txn(1'b0, 9, 1'b1, 0);

        // Token in S_DATA ignored, then asynchronous reset mid-R_HAND
        tick();
        token_valid = 1'b1; token_out = 1'b0;
        tick(); clear_inputs();
        done_send_data = 1'b1;
        tick(); clear_inputs();
        r_hand_nak = 1'b1;
        tick(); clear_inputs();
        token_valid = 1'b1; token_out = 1'b1;
        tick(); clear_inputs();
        check("tok_in_sdata_busy", busy, 1);
        check("tok_in_sdata_pulses", {r_data_start, start_send_data}, 0);
        check("tok_in_sdata_fail_count", fail_count, 1);
        done_send_data = 1'b1;
        tick(); clear_inputs();
        check("tok_in_sdata_r_hand", r_hand, 1);
        #2 rst_l = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 9'b100000000);
        check("async_reset_fail_count", fail_count, 0);
        @(negedge clk);
        rst_l = 1'b1;
        token_valid = 1'b1; token_out = 1'b1;
        tick(); clear_inputs();
        check("first_token_after_reset", r_data_start, 1);
        r_data_finish = 1'b1;
        tick(); clear_inputs();
        done_send_hand = 1'b1;
        tick(); clear_inputs();
        check("post_reset_txn_ok", {transfer_done, transfer_ok}, 2'b11);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, MAX_RETRY + 2),
                    1'($urandom_range(0, 1)), 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
